// File: rtl/preg_free_list.sv
// preg_free_list: dual-issue physical register free list with committed head for recovery
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PW = $clog2(NUM_PREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req1,
  input  logic          alloc_req2,
  output logic          alloc_gnt1,
  output logic          alloc_gnt2,
  output logic [PW-1:0] alloc_preg1,
  output logic [PW-1:0] alloc_preg2,
  output logic          alloc_stall,
  input  logic          free_valid1,
  input  logic [PW-1:0] free_preg1,
  input  logic          free_valid2,
  input  logic [PW-1:0] free_preg2,
  input  logic [1:0]    commit_alloc,
  input  logic          recover,
  output logic [PW:0]   free_count,
  output logic          overflow_err
);
  localparam logic [PW:0] MAX_CNT = (PW+1)'(NUM_PREGS-1);
  logic [PW-1:0] mem_q [NUM_PREGS];
  logic [PW:0] head_q, head_d, chead_q, chead_d, tail_q, tail_d, h1, t1, ng;
  logic ovf_q, ovf_d, ok, nz1, nz2, w1, w2;
  assign free_count   = tail_q - head_q;
  assign overflow_err = ovf_q;
  assign h1           = head_q + (PW+1)'(1);
  assign t1           = tail_q + (PW+1)'(w1);
  // grants are all-or-nothing; slot 1 always takes the older entry
  always_comb begin
    ok          = !recover && ((PW+1)'(alloc_req1) + (PW+1)'(alloc_req2) <= free_count);
    alloc_gnt1  = alloc_req1 && ok;
    alloc_gnt2  = alloc_req2 && ok;
    alloc_stall = (alloc_req1 || alloc_req2) && !ok;
    alloc_preg1 = mem_q[head_q[PW-1:0]];
    alloc_preg2 = alloc_req1 ? mem_q[h1[PW-1:0]] : mem_q[head_q[PW-1:0]];
    ng          = (PW+1)'(alloc_gnt1) + (PW+1)'(alloc_gnt2);
    nz1         = free_valid1 && (free_preg1 != '0);
    nz2         = free_valid2 && (free_preg2 != '0);
    w1          = nz1 && (free_count < MAX_CNT);
    w2          = nz2 && (free_count + (PW+1)'(w1) < MAX_CNT);
    ovf_d       = ovf_q || (nz1 && !w1) || (nz2 && !w2);
    tail_d      = t1 + (PW+1)'(w2);
    chead_d     = chead_q + (PW+1)'(commit_alloc);
    head_d      = recover ? chead_d : head_q + ng;
  end
  // pointer, sticky error and entry storage update; p0 is never written back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        mem_q[i] <= (i < NUM_PREGS-NUM_AREGS) ? PW'(NUM_AREGS+i) : '0;
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= (PW+1)'(NUM_PREGS-NUM_AREGS);
      ovf_q   <= 1'b0;
    end else begin
      if (w1) mem_q[tail_q[PW-1:0]] <= free_preg1;
      if (w2) mem_q[t1[PW-1:0]] <= free_preg2;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list: directed vectors with a queued scoreboard for preg_free_list
module tb_preg_free_list;
  logic clk = 0, rst = 1;
  logic r1 = 0, r2 = 0, fv1 = 0, fv2 = 0, rc = 0;
  logic [5:0] fp1 = 0, fp2 = 0;
  logic [1:0] ca = 0;
  logic g1, g2, st, ovf;
  logic [5:0] p1, p2;
  logic [6:0] cnt;
  int vectors = 0, miscompares = 0;
  int h = 0, ch = 0;

  typedef struct {
    string nm;
    logic g1, g2, st, ovf;
    int p1, p2, cnt;
  } exp_t;
  exp_t q[$];

  preg_free_list dut (
    .clk(clk), .rst(rst),
    .alloc_req1(r1), .alloc_req2(r2),
    .alloc_gnt1(g1), .alloc_gnt2(g2),
    .alloc_preg1(p1), .alloc_preg2(p2),
    .alloc_stall(st),
    .free_valid1(fv1), .free_preg1(fp1),
    .free_valid2(fv2), .free_preg2(fp2),
    .commit_alloc(ca), .recover(rc),
    .free_count(cnt), .overflow_err(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      assert (cnt <= 7'd63) else $error("free_count above capacity: %0d", cnt);
      if (g1 !== e.g1 || g2 !== e.g2 || st !== e.st || ovf !== e.ovf || cnt !== 7'(e.cnt) ||
          (e.p1 >= 0 && p1 !== 6'(e.p1)) || (e.p2 >= 0 && p2 !== 6'(e.p2))) begin
        miscompares++;
        $display("FAIL %s: got gnt=%b%b stall=%b p1=%0d p2=%0d cnt=%0d ovf=%b, want gnt=%b%b stall=%b p1=%0d p2=%0d cnt=%0d ovf=%b",
                 e.nm, g1, g2, st, p1, p2, cnt, ovf, e.g1, e.g2, e.st, e.p1, e.p2, e.cnt, e.ovf);
      end
    end
  end

  task automatic step(input string nm, input logic a1, a2, f1, input logic [5:0] x1,
                      input logic f2, input logic [5:0] x2, input logic [1:0] c,
                      input logic rv, rs, eg1, eg2, est, input int ep1, ep2, ecnt,
                      input logic eovf);
    exp_t e;
    r1 = a1; r2 = a2; fv1 = f1; fp1 = x1; fv2 = f2; fp2 = x2; ca = c; rc = rv; rst = rs;
    e.nm = nm; e.g1 = eg1; e.g2 = eg2; e.st = est; e.p1 = ep1; e.p2 = ep2; e.cnt = ecnt; e.ovf = eovf;
    q.push_back(e);
    if (rs) begin h = 0; ch = 0; end
    else begin
      ch += int'(c);
      h = rv ? ch : h + int'(eg1) + int'(eg2);
    end
    assert (ch <= h) else $error("commit_alloc moved chead past head");
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step("reset_idle", 0,0,0,0,0,0,0,0,0, 0,0,0, 32,32,32,0);
    step("dual_alloc", 1,1,0,0,0,0,0,0,0, 1,1,0, 32,33,32,0);
    step("after_dual", 0,0,0,0,0,0,0,0,0, 0,0,0, 34,-1,30,0);
    step("req2_only",  0,1,0,0,0,0,0,0,0, 0,1,0, 34,34,30,0);
    step("commit2",    0,0,0,0,0,0,2,0,0, 0,0,0, 35,-1,29,0);
    step("commit1",    0,0,0,0,0,0,1,0,0, 0,0,0, 35,-1,29,0);
    for (int i = 0; i < 14; i++)
      step("drain", 1,1,0,0,0,0,0,0,0, 1,1,0, 35+2*i,36+2*i,29-2*i,0);
    step("stall_cnt1", 1,1,1,5,0,0,0,0,0, 0,0,1, 63,-1,1,0);
    step("grant_63_5", 1,1,0,0,0,0,0,0,0, 1,1,0, 63,5,2,0);
    step("empty_zero", 1,0,1,0,0,0,0,0,0, 0,0,1, -1,-1,0,0);
    step("zero_ignore",0,0,0,0,0,0,0,0,0, 0,0,0, -1,-1,0,0);
    step("reset_mid",  0,0,0,0,0,0,0,0,1, 0,0,0, -1,-1,0,0);
    step("rec_alloc1", 1,1,0,0,0,0,2,0,0, 1,1,0, 32,33,32,0);
    step("rec_alloc2", 1,1,0,0,0,0,0,0,0, 1,1,0, 34,35,30,0);
    step("recover",    1,0,0,0,0,0,0,1,0, 0,0,1, 36,-1,28,0);
    step("post_recov", 0,0,0,0,0,0,0,0,0, 0,0,0, 34,-1,30,0);
    for (int i = 0; i < 16; i++)
      step("fill", 0,0,1,1,1,2,0,0,0, 0,0,0, 34,-1,30+2*i,0);
    step("one_slot",   0,0,1,3,1,4,0,0,0, 0,0,0, 34,-1,62,0);
    step("full_drop",  0,0,1,3,1,4,0,0,0, 0,0,0, 34,-1,63,1);
    step("full_hold",  0,0,0,0,0,0,0,0,0, 0,0,0, 34,-1,63,1);
    step("ovf_sticky", 1,0,0,0,0,0,0,0,0, 1,0,0, 34,-1,63,1);
    step("ovf_after",  0,0,0,0,0,0,0,0,0, 0,0,0, 35,-1,62,1);
    step("rst_busy",   1,1,1,7,1,9,1,0,1, 1,1,0, 35,36,62,1);
    step("rst_values", 0,0,0,0,0,0,0,0,0, 0,0,0, 32,32,32,0);
    step("rst_req2",   0,1,0,0,0,0,0,0,0, 0,1,0, 32,32,32,0);
    step("rst_final",  0,0,0,0,0,0,0,0,0, 0,0,0, 33,-1,31,0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d pending, want 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
